// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_pkg
//  Description : Shared types and helpers for the round-robin one-hot arbiter.
//                Holds the FSM state type, the rotating first-set search and
//                the one-hot to index encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    // Widest requester vector the helper functions accept.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_state_t;

    // Round-robin pick over the low n bits of req, starting at index ptr.
    // Equivalent to rotating req right by ptr, taking the first set bit and
    // rotating the result back. The result is one-hot, or zero if req is zero.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input int                    n,
        input int                    ptr,
        input logic [RR_MAX_REQ-1:0] req
    );
        logic [RR_MAX_REQ-1:0] res;
        logic                  found;
        int                    idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    res[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Encode a one-hot vector into its bit index (zero for an all-zero input).
    function automatic logic [RR_IDX_W-1:0] onehot2idx(
        input logic [RR_MAX_REQ-1:0] oh
    );
        logic [RR_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | RR_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_mux.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_mux
//  Description : AND-OR multiplexer driven by a one-hot select. With at most
//                one select bit set, no priority logic is needed; an all-zero
//                select yields zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_mux #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic [NUM_REQ-1:0]       i_sel,
    input  logic [NUM_REQ*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]         o_data
);

    logic [WIDTH-1:0] w_acc;

    // OR together every data slice masked by its select bit.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_acc = w_acc | (i_data[i*WIDTH +: WIDTH] & {WIDTH{i_sel[i]}});
        end
    end

    assign o_data = w_acc;

endmodule
`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_onehot_arbiter
//  Description : Round-robin arbiter with a registered one-hot grant, bounded
//                grant hold time and zero-bubble hand-over. The granted
//                requester's data is steered out through a one-hot mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    rr_state_t          r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [NUM_REQ-1:0] r_grant;

    rr_state_t          w_state_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_hold_cnt_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;

    logic [PTR_W-1:0]   w_g_idx;
    logic [PTR_W-1:0]   w_next_start;
    logic [NUM_REQ-1:0] w_pick_idle;
    logic [NUM_REQ-1:0] w_pick_rel;
    logic               w_release;

    // Index of the current holder and the slot just after it (wrapping).
    assign w_g_idx      = PTR_W'(onehot2idx(RR_MAX_REQ'(r_grant)));
    assign w_next_start = (w_g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_g_idx + 1'b1);

    // Candidate grants: from the stored pointer when idle, and from the slot
    // after the holder on release so a timed-out holder drops to last place.
    assign w_pick_idle = NUM_REQ'(rr_pick(NUM_REQ, int'(r_ptr), RR_MAX_REQ'(req_i)));
    assign w_pick_rel  = NUM_REQ'(rr_pick(NUM_REQ, int'(w_next_start), RR_MAX_REQ'(req_i)));

    // Holder lets go when it stops requesting or has used its full window.
    assign w_release = (~|(req_i & r_grant)) || (r_hold_cnt == CNT_W'(MAX_HOLD));

    // State, pointer, hold counter and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    // Next-state logic: grant from idle, hold, or hand over without a bubble.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_grant_nxt    = r_grant;
        unique case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                if (|req_i) begin
                    w_grant_nxt    = w_pick_idle;
                    w_hold_cnt_nxt = CNT_W'(1);
                    w_state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_ptr_nxt   = w_next_start;
                    w_grant_nxt = w_pick_rel;
                    if (|w_pick_rel) begin
                        w_hold_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = IDLE;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_grant_nxt    = '0;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    onehot_mux #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) u_mux (
        .i_sel  (r_grant),
        .i_data (data_i),
        .o_data (data_o)
    );

    assign grant_o = r_grant;
    assign valid_o = |r_grant;

endmodule
`default_nettype wire

// File: doc/rr_onehot_arbiter.md
# rr_onehot_arbiter

Round-robin arbiter that shares one output channel among `NUM_REQ` requesters. It issues a registered one-hot grant and steers the granted requester's data through an internal AND-OR one-hot mux. A grant is held while its requester keeps `req_i` high, up to `MAX_HOLD` cycles. The block sits in front of any shared datapath that is driven by a one-hot select.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: data width per requester.
- `MAX_HOLD`, 8: maximum consecutive cycles one grant is held, ≥1.

- `clk`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req_i`  input  NUM_REQ  per-requester request level.
- `data_i`  input  NUM_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- `grant_o`  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- `valid_o`  output  1  `|grant_o`.
- `data_o`  output  WIDTH  OR over i of (`data_i[i]` & {WIDTH{`grant_o[i]`}}); zero when idle.

## Operation
- State: `IDLE` or `BUSY`. Round-robin pointer `ptr` (clog2(NUM_REQ) bits). Hold counter `hold_cnt` (clog2(MAX_HOLD+1) bits).
- Arbitration function `pick(ptr, req)`: return the first set bit of `req`, searching from index `ptr` upward and wrapping modulo NUM_REQ. Output is one-hot, or zero if `req` is zero.
- `IDLE` state:
  - if `|req_i`: `grant_o` <= pick(ptr, req_i), `hold_cnt` <= 1, go to `BUSY`.
  - otherwise stay in `IDLE`, `grant_o` = 0.
- `BUSY` state, with granted index g:
  - Release condition: `req_i[g]`==0, or `hold_cnt`==MAX_HOLD.
  - No release: keep `grant_o`, `hold_cnt`++. A higher-priority request does not preempt the grant.
  - Release: `ptr` <= (g+1) mod NUM_REQ. Then `grant_o` <= pick((g+1) mod NUM_REQ, req_i) in the same cycle, with no bubble.
    - If that pick is non-zero: `hold_cnt` <= 1, stay in `BUSY`.
    - If that pick is zero: go to `IDLE`, `grant_o` <= 0.
  - On timeout, a requester that is still asserting gets the lowest priority. It re-wins only if it is the only requester.
- `ptr` changes only on release.
- `MAX_HOLD`=1 gives one cycle per grant, i.e. pure rotation.
- `grant_o` is never multi-hot. The mux therefore needs no priority logic.

## Timing
- Reset values: `grant_o`=0, `valid_o`=0, `data_o`=0, `ptr`=0, `hold_cnt`=0, state `IDLE`.
- `reset` takes priority over every other input in the same edge. A reset during `BUSY` drops the grant on the next edge, and `ptr` returns to 0.
- Request-to-grant latency: 1 cycle. `req_i` sampled at edge N gives `grant_o` valid after edge N.
- Release-to-next-grant latency: 0 cycles. The old grant's last cycle is followed directly by the new grant.
- `data_o` and `valid_o` are combinational from `grant_o` and `data_i`. There is no added register stage.
- A requester that drops `req_i` and re-asserts it in the same cycle that another requester releases is arbitrated normally using the new `ptr`.

## Structure
- Shared package `rr_arb_pkg` holds:
  - `typedef enum logic {IDLE, BUSY} rr_state_t`
  - function `rr_pick` (rotate, find-first-set, rotate back)
  - function `onehot2idx`
- Sub-module `onehot_mux`, parameterised on `NUM_REQ` and `WIDTH`: a pure AND-OR mux taking a one-hot select and packed data. It is instantiated once.
- `rr_onehot_arbiter` holds the FSM, `ptr`, `hold_cnt` and the `grant_o` register.

## Test plan
- Reset, then `req_i`=4'b0000 for 5 cycles: `grant_o`=0, `valid_o`=0, `data_o`=0 throughout.
- `req_i`=4'b1111 held, MAX_HOLD=2, `data_i`={8'hD3,8'hC2,8'hB1,8'hA0}. Grant sequence is 0001,0001,0010,0010,0100,0100,1000,1000,0001…, with `data_o` following A0,A0,B1,B1,…
- Grant held on requester 2, then `req_i[2]` drops while `req_i`=4'b0011. The next cycle gives `grant_o`=4'b0001, via wrap from `ptr`=3 to index 0.
- Only `req_i[1]` held with MAX_HOLD=3. `grant_o` stays 4'b0010 continuously. Timeout re-grants the same requester with no bubble, and `hold_cnt` returns to 1 after 3 cycles.
- Pulse `reset` mid-grant on requester 3. The next cycle gives `grant_o`=0. With `req_i`=4'b1000 still high, grant 4'b1000 returns 1 cycle after `reset` deasserts.
- Random `req_i` for 10k cycles. Assertions:
  - `$onehot0(grant_o)` always holds.
  - No grant lasts longer than MAX_HOLD cycles.
  - A requester that is continuously asserting is granted within (NUM_REQ-1)*MAX_HOLD+1 cycles.
